// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-field layout of each stage boundary and
// the derived payload widths used to size pipe_stage_reg instances.
package pipe_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int WORD_W       = 32;
  localparam int PERF_CNT_W   = 16;

  // ID/EX control field widths
  localparam int REG_WR_W     = 1;
  localparam int MEM_WR_W     = 1;
  localparam int MEM_RD_W     = 1;
  localparam int BRANCH_W     = 1;
  localparam int MEM_TO_REG_W = 1;
  localparam int PC_SRC_W     = 2;
  localparam int REG_DST_W    = 2;
  localparam int ALU_SRC1_W   = 1;
  localparam int ALU_SRC2_W   = 2;
  localparam int SIGN_W       = 1;

  // ID/EX field offsets inside up_ctrl/dn_ctrl, packed LSB first
  localparam int ID_EX_REG_WR_OFF     = 0;
  localparam int ID_EX_MEM_WR_OFF     = ID_EX_REG_WR_OFF     + REG_WR_W;
  localparam int ID_EX_MEM_RD_OFF     = ID_EX_MEM_WR_OFF     + MEM_WR_W;
  localparam int ID_EX_BRANCH_OFF     = ID_EX_MEM_RD_OFF     + MEM_RD_W;
  localparam int ID_EX_MEM_TO_REG_OFF = ID_EX_BRANCH_OFF     + BRANCH_W;
  localparam int ID_EX_PC_SRC_OFF     = ID_EX_MEM_TO_REG_OFF + MEM_TO_REG_W;
  localparam int ID_EX_REG_DST_OFF    = ID_EX_PC_SRC_OFF     + PC_SRC_W;
  localparam int ID_EX_ALU_SRC1_OFF   = ID_EX_REG_DST_OFF    + REG_DST_W;
  localparam int ID_EX_ALU_SRC2_OFF   = ID_EX_ALU_SRC1_OFF   + ALU_SRC1_W;
  localparam int ID_EX_SIGN_OFF       = ID_EX_ALU_SRC2_OFF   + ALU_SRC2_W;
  localparam int ID_EX_RS_OFF         = ID_EX_SIGN_OFF       + SIGN_W;
  localparam int ID_EX_RT_OFF         = ID_EX_RS_OFF         + REG_ADDR_W;
  localparam int ID_EX_RD_OFF         = ID_EX_RT_OFF         + REG_ADDR_W;
  localparam int ID_EX_CTRL_W         = ID_EX_RD_OFF         + REG_ADDR_W;

  // EX/MEM keeps only what the memory and write-back stages consume
  localparam int EX_MEM_REG_WR_OFF     = 0;
  localparam int EX_MEM_MEM_WR_OFF     = EX_MEM_REG_WR_OFF     + REG_WR_W;
  localparam int EX_MEM_MEM_RD_OFF     = EX_MEM_MEM_WR_OFF     + MEM_WR_W;
  localparam int EX_MEM_MEM_TO_REG_OFF = EX_MEM_MEM_RD_OFF     + MEM_RD_W;
  localparam int EX_MEM_RD_OFF         = EX_MEM_MEM_TO_REG_OFF + MEM_TO_REG_W;
  localparam int EX_MEM_CTRL_W         = EX_MEM_RD_OFF         + REG_ADDR_W;

  localparam int MEM_WB_REG_WR_OFF     = 0;
  localparam int MEM_WB_MEM_TO_REG_OFF = MEM_WB_REG_WR_OFF     + REG_WR_W;
  localparam int MEM_WB_RD_OFF         = MEM_WB_MEM_TO_REG_OFF + MEM_TO_REG_W;
  localparam int MEM_WB_CTRL_W         = MEM_WB_RD_OFF         + REG_ADDR_W;

  // ID/EX data: rs value, rt value, immediate, instruction, PC+4
  localparam int ID_EX_DATA_W = 5 * WORD_W;

  function automatic logic [REG_ADDR_W-1:0] id_ex_rd(input logic [ID_EX_CTRL_W-1:0] c);
    return c[ID_EX_RD_OFF +: REG_ADDR_W];
  endfunction

  function automatic logic id_ex_mem_access(input logic [ID_EX_CTRL_W-1:0] c);
    return c[ID_EX_MEM_WR_OFF] | c[ID_EX_MEM_RD_OFF];
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional one-entry skid slot,
// flush-to-bubble and saturating stall/flush performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = ID_EX_DATA_W,
  parameter int CTRL_W     = ID_EX_CTRL_W,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = PERF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Handshake: a beat moves on a side exactly when valid and ready are both
  // high at a rising clk edge; valid never depends on ready on either side.

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t main_q, main_d;
  slot_t skid_q, skid_d;
  slot_t up_slot;
  logic  in_fire;
  logic  out_fire;
  logic  stall_inc;
  logic  flush_inc;

  // An emptied slot never carries live control bits downstream.
  function automatic slot_t drained(input slot_t s);
    slot_t r;
    r = '0;
    if (CLEAR_DATA == 0) r.data = s.data;
    return r;
  endfunction

  always_comb begin
    up_slot       = '0;
    up_slot.valid = 1'b1;
    up_slot.ctrl  = up_ctrl;
    up_slot.data  = up_data;
  end

  always_comb begin
    if (SKID != 0) up_ready = ~skid_q.valid;
    else           up_ready = dn_ready | ~main_q.valid;
  end

  assign in_fire  = up_valid & up_ready;
  assign out_fire = main_q.valid & dn_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = drained(main_q);
      skid_d = drained(skid_q);
    end else if (SKID != 0) begin
      if (!main_q.valid || out_fire) begin
        if (skid_q.valid) begin
          main_d = skid_q;
          skid_d = in_fire ? up_slot : drained(skid_q);
        end else if (in_fire) begin
          main_d = up_slot;
        end else begin
          main_d = drained(main_q);
        end
      end else if (in_fire) begin
        skid_d = up_slot;
      end
    end else begin
      if (in_fire) begin
        main_d = up_slot;
      end else if (out_fire) begin
        main_d = drained(main_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign dn_valid = main_q.valid;
  assign dn_data  = main_q.data;
  assign dn_ctrl  = main_q.ctrl;

  assign stall_inc = main_q.valid & ~dn_ready;
  assign flush_inc = flush & (main_q.valid | skid_q.valid);

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven side by side, each
// checked every cycle against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 28;
  localparam int BW = CW + DW;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic reset, dn_ready, flush, cnt_clr;
  logic          up_valid_d [N];
  logic [DW-1:0] up_data_d  [N];
  logic [CW-1:0] up_ctrl_d  [N];
  logic          up_ready_w [N];
  logic          dn_valid_w [N];
  logic [DW-1:0] dn_data_w  [N];
  logic [CW-1:0] dn_ctrl_w  [N];
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1, sc2, fc2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit model_known = 1'b0;
  bit gap_en = 1'b0;
  bit cap_en = 1'b0;

  logic [BW:0]   src_q [N][$];
  logic [BW-1:0] exp_q [N][$];
  int exp_stall [N];
  int exp_flush [N];
  logic [DW-1:0] cap_q[$];
  int            cap_cyc[$];

  // dut0: skid, data held; dut1: no skid, data cleared, 2-bit counters;
  // dut2: skid, data cleared, 2-bit counters.
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLEAR_DATA(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .up_valid(up_valid_d[0]), .up_ready(up_ready_w[0]),
    .up_data(up_data_d[0]), .up_ctrl(up_ctrl_d[0]), .dn_valid(dn_valid_w[0]),
    .dn_ready(dn_ready), .dn_data(dn_data_w[0]), .dn_ctrl(dn_ctrl_w[0]),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc0), .flush_cnt(fc0));
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLEAR_DATA(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .up_valid(up_valid_d[1]), .up_ready(up_ready_w[1]),
    .up_data(up_data_d[1]), .up_ctrl(up_ctrl_d[1]), .dn_valid(dn_valid_w[1]),
    .dn_ready(dn_ready), .dn_data(dn_data_w[1]), .dn_ctrl(dn_ctrl_w[1]),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc1), .flush_cnt(fc1));
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLEAR_DATA(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .up_valid(up_valid_d[2]), .up_ready(up_ready_w[2]),
    .up_data(up_data_d[2]), .up_ctrl(up_ctrl_d[2]), .dn_valid(dn_valid_w[2]),
    .dn_ready(dn_ready), .dn_data(dn_data_w[2]), .dn_ctrl(dn_ctrl_w[2]),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc2), .flush_cnt(fc2));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit skid_of(int i);  return i != 1; endfunction
  function automatic bit clear_of(int i); return i != 0; endfunction
  function automatic int cmax(int i);     return (i == 0) ? 65535 : 3; endfunction

  function automatic int stall_got(int i);
    case (i)
      0:       return int'(sc0);
      1:       return int'(sc1);
      default: return int'(sc2);
    endcase
  endfunction

  function automatic int flush_got(int i);
    case (i)
      0:       return int'(fc0);
      1:       return int'(fc1);
      default: return int'(fc2);
    endcase
  endfunction

  task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h expected=%0h cyc=%0d", name, id, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_beat(input int i, input logic [DW-1:0] data, input bit once);
    logic [31:0] r;
    r = $urandom();
    src_q[i].push_back({once, r[CW-1:0], data});
  endtask

  task automatic clear_counters();
    tick(); cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0;
  endtask

  // Upstream source: presents the head of src_q, pops it after a handshake;
  // one-shot beats are withdrawn after a single cycle either way.
  bit pres [N];
  bit fire_pend [N];
  initial begin : source
    logic [BW:0]  head;
    logic [31:0]  r;
    for (int i = 0; i < N; i++) begin
      up_valid_d[i] = 1'b0; up_data_d[i] = '0; up_ctrl_d[i] = '0;
      pres[i] = 1'b0; fire_pend[i] = 1'b0;
    end
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (pres[i] && src_q[i].size() > 0) begin
          head = src_q[i][0];
          if (fire_pend[i] || head[BW]) void'(src_q[i].pop_front());
        end
        pres[i] = 1'b0;
        up_valid_d[i] = 1'b0;
        if (reset) begin
          r = $urandom();
          up_valid_d[i] = 1'b1; up_ctrl_d[i] = '1; up_data_d[i] = r;
        end else if (src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          head = src_q[i][0];
          up_valid_d[i] = 1'b1;
          up_ctrl_d[i]  = head[BW-1:DW];
          up_data_d[i]  = head[DW-1:0];
          pres[i] = 1'b1;
        end
      end
      #1;
      for (int i = 0; i < N; i++) fire_pend[i] = pres[i] && (up_ready_w[i] === 1'b1);
    end
  end

  // ---------------- scoreboard / model ----------------
  // The stage is a FIFO of capacity 2 (skid) or 1 (no skid); compare the DUT
  // against it, then advance it by the handshakes of the coming edge.
  initial begin : model_chk
    logic [BW-1:0] head;
    int sz;
    bit exp_ur, inf, outf;
    forever begin
      @(negedge clk); #3;
      if (model_known && cap_en && dn_valid_w[0] === 1'b1 && dn_ready) begin
        cap_q.push_back(dn_data_w[0]);
        cap_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        sz = exp_q[i].size();
        head = (sz > 0) ? exp_q[i][0] : '0;
        exp_ur = skid_of(i) ? (sz < 2) : (dn_ready || sz == 0);
        if (model_known) begin
          chk("up_ready", i, 64'(up_ready_w[i]), 64'(exp_ur));
          chk("dn_valid", i, 64'(dn_valid_w[i]), 64'(sz > 0));
          chk("dn_ctrl", i, 64'(dn_ctrl_w[i]), 64'(head[BW-1:DW]));
          if (sz > 0 || clear_of(i)) chk("dn_data", i, 64'(dn_data_w[i]), 64'(head[DW-1:0]));
          chk("stall_cnt", i, 64'(stall_got(i)), 64'(exp_stall[i]));
          chk("flush_cnt", i, 64'(flush_got(i)), 64'(exp_flush[i]));
        end
        if (reset) begin
          exp_q[i].delete();
          exp_stall[i] = 0;
          exp_flush[i] = 0;
        end else if (model_known) begin
          inf  = up_valid_d[i] && exp_ur;
          outf = (sz > 0) && dn_ready;
          if (cnt_clr) begin
            exp_stall[i] = 0;
            exp_flush[i] = 0;
          end else begin
            if (sz > 0 && !dn_ready && exp_stall[i] < cmax(i)) exp_stall[i]++;
            if (flush && sz > 0 && exp_flush[i] < cmax(i)) exp_flush[i]++;
          end
          if (flush) begin
            exp_q[i].delete();
          end else begin
            if (outf) void'(exp_q[i].pop_front());
            if (inf) exp_q[i].push_back({up_ctrl_d[i], up_data_d[i]});
          end
        end
      end
      if (reset) model_known = 1'b1;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int p, t;
    logic [31:0] r;
    reset = 1'b1; dn_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;

    // reset held two edges with an all-ones junk beat offered
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      chk("rst_dn_valid", i, 64'(dn_valid_w[i]), 64'd0);
      chk("rst_dn_ctrl", i, 64'(dn_ctrl_w[i]), 64'd0);
      chk("rst_dn_data", i, 64'(dn_data_w[i]), 64'd0);
      chk("rst_stall_cnt", i, 64'(stall_got(i)), 64'd0);
      chk("rst_up_ready", i, 64'(up_ready_w[i]), 64'd1);
    end

    // streaming 1..8 at full throughput, one-cycle latency
    cap_q.delete(); cap_cyc.delete(); cap_en = 1'b1;
    p = cyc;
    for (int k = 1; k <= 8; k++)
      for (int i = 0; i < N; i++) push_beat(i, DW'(k), 1'b0);
    for (t = 0; t < 30 && cap_q.size() < 8; t++) tick();
    chk("stream_count", 0, 64'(cap_q.size()), 64'd8);
    for (int k = 0; k < cap_q.size() && k < 8; k++) begin
      chk("stream_data", 0, 64'(cap_q[k]), 64'(k + 1));
      chk("stream_cyc", 0, 64'(cap_cyc[k]), 64'(p + 1 + k));
    end
    repeat (3) tick();

    // stall for three cycles once 0x10 is on the output
    clear_counters();
    cap_q.delete(); cap_cyc.delete();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) push_beat(i, DW'(32'h10 + k), 1'b0);
    for (t = 0; t < 10; t++) begin
      tick();
      if (dn_valid_w[0] === 1'b1 && dn_data_w[0] === DW'(32'h10)) break;
    end
    chk("stall_seen", 0, 64'(t < 10), 64'd1);
    dn_ready = 1'b0;
    repeat (2) begin
      tick();
      chk("stall_hold", 0, 64'(dn_data_w[0]), 64'h10);
      chk("stall_up_ready", 0, 64'(up_ready_w[0]), 64'd0);
      chk("stall_up_ready", 1, 64'(up_ready_w[1]), 64'd0);
      chk("stall_up_ready", 2, 64'(up_ready_w[2]), 64'd0);
    end
    tick();
    chk("stall_cnt3", 0, 64'(stall_got(0)), 64'd3);
    chk("stall_cnt3", 1, 64'(stall_got(1)), 64'd3);
    dn_ready = 1'b1;
    for (t = 0; t < 10 && cap_q.size() < 3; t++) tick();
    chk("stall_out_count", 0, 64'(cap_q.size()), 64'd3);
    for (int k = 0; k < cap_q.size() && k < 3; k++)
      chk("stall_out_data", 0, 64'(cap_q[k]), 64'(32'h10 + k));
    if (cap_q.size() >= 3) begin
      chk("stall_b2b", 0, 64'(cap_cyc[1]), 64'(cap_cyc[0] + 1));
      chk("stall_b2b", 0, 64'(cap_cyc[2]), 64'(cap_cyc[0] + 2));
    end
    repeat (3) tick();

    // flush with main and skid full and a one-shot 0x99 offered
    tick();
    dn_ready = 1'b0;
    for (int i = 0; i < N; i++) push_beat(i, DW'(32'h20), 1'b0);
    push_beat(0, DW'(32'h21), 1'b0);
    push_beat(2, DW'(32'h21), 1'b0);
    for (t = 0; t < 10; t++) begin
      tick();
      if (up_ready_w[0] === 1'b0 && up_ready_w[2] === 1'b0 && dn_valid_w[1] === 1'b1) break;
    end
    chk("flush_fill", 0, 64'(t < 10), 64'd1);
    for (int i = 0; i < N; i++) push_beat(i, DW'(32'h99), 1'b1);
    flush = 1'b1;
    cap_q.delete(); cap_cyc.delete();
    tick();
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("flush_dn_valid", i, 64'(dn_valid_w[i]), 64'd0);
      chk("flush_dn_ctrl", i, 64'(dn_ctrl_w[i]), 64'd0);
      chk("flush_cnt1", i, 64'(flush_got(i)), 64'd1);
    end
    chk("flush_dn_data", 1, 64'(dn_data_w[1]), 64'd0);
    chk("flush_dn_data", 2, 64'(dn_data_w[2]), 64'd0);
    dn_ready = 1'b1;
    repeat (4) tick();
    chk("flush_no_beat", 0, 64'(dn_valid_w[0]), 64'd0);
    chk("flush_no_out", 0, 64'(cap_q.size()), 64'd0);

    // counter saturation at 2 bits, then clear during a stall
    clear_counters();
    for (int i = 0; i < N; i++) push_beat(i, DW'(32'h30), 1'b0);
    for (t = 0; t < 10; t++) begin
      tick();
      if (dn_valid_w[1] === 1'b1) break;
    end
    dn_ready = 1'b0;
    repeat (6) tick();
    chk("sat_stall", 0, 64'(stall_got(0)), 64'd6);
    chk("sat_stall", 1, 64'(stall_got(1)), 64'd3);
    chk("sat_stall", 2, 64'(stall_got(2)), 64'd3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_over_inc", 0, 64'(stall_got(0)), 64'd0);
    chk("clr_over_inc", 1, 64'(stall_got(1)), 64'd0);
    dn_ready = 1'b1;
    repeat (3) tick();

    // randomized traffic: back-pressure, flushes, counter clears, resets
    cap_en = 1'b0;
    gap_en = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      tick();
      dn_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      cnt_clr  = ($urandom_range(0, 150) == 0);
      reset    = ($urandom_range(0, 300) == 0);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(0, 1) == 1) begin
          r = $urandom();
          push_beat(i, r, 1'b0);
        end
      end
    end
    tick();
    reset = 1'b0; flush = 1'b0; cnt_clr = 1'b0; dn_ready = 1'b1; gap_en = 1'b0;
    for (t = 0; t < 100; t++) begin
      tick();
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          dn_valid_w[0] === 1'b0 && dn_valid_w[1] === 1'b0 && dn_valid_w[2] === 1'b0) break;
    end
    chk("drain", 0, 64'(t < 100), 64'd1);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    bad++;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
